// File: rtl/firebird7_in_gate2_ijtag_scan_sequencer.sv
// IJTAG scan-access sequencer for the gate2 SIB/TDR segment: one host request
// becomes capture -> shift N -> update on the network, returned as one response.
module firebird7_in_gate2_ijtag_scan_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CNT_W-1:0]   req_len,
    input  logic [MAX_LEN-1:0] req_data,
    input  logic               req_no_capture,
    input  logic               req_no_update,
    input  logic               abort,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_from_so
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic               noupd_q, noupd_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               sel_q, ce_q, se_q, ue_q, si_q;
    logic               req_ready_q, rsp_valid_q, busy_q;
    logic               len_bad;

    assign len_bad = (req_len == '0) || (req_len > MAX_LEN_C);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        noupd_d    = noupd_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rsp_data_d = '0;
                    if (len_bad) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        len_d     = req_len;
                        data_d    = req_data;
                        noupd_d   = req_no_update;
                        cnt_d     = '0;
                        state_d   = req_no_capture ? S_SHIFT : S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // An abort drops the bit of the cycle it arrives in.
                if (abort) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    rsp_data_d[cnt_q[IDX_W-1:0]] = ijtag_from_so;
                    if (cnt_q == len_q - ONE_C) begin
                        state_d = noupd_q ? S_RESP : S_UPDATE;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
            end
            S_UPDATE: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Network controls are decoded from the next state so they come straight off flops.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            noupd_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            sel_q       <= 1'b0;
            ce_q        <= 1'b0;
            se_q        <= 1'b0;
            ue_q        <= 1'b0;
            si_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            noupd_q     <= noupd_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            sel_q       <= (state_d == S_CAPTURE) || (state_d == S_SHIFT) || (state_d == S_UPDATE);
            ce_q        <= (state_d == S_CAPTURE);
            se_q        <= (state_d == S_SHIFT);
            ue_q        <= (state_d == S_UPDATE);
            si_q        <= (state_d == S_SHIFT) ? data_d[cnt_d[IDX_W-1:0]] : 1'b0;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign ijtag_sel = sel_q;
    assign ijtag_ce  = ce_q;
    assign ijtag_se  = se_q;
    assign ijtag_ue  = ue_q;
    assign ijtag_si  = si_q;

endmodule
